// File: rtl/processor_seq.sv
// Trace-driven request sequencer.
// Replays a small table of addresses as cache read requests, either once or in
// a loop, and accumulates a count and XOR checksum of the returned read data.
module processor_seq #(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 16,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ldEn,
   input  logic [IDX_W-1:0]  i_ldIdx,
   input  logic [ADDR_W-1:0] i_ldAddr,
   input  logic              i_start,
   input  logic [IDX_W:0]    i_len,
   input  logic              i_oneShot,
   input  logic              i_stop,
   output logic              o_reqValid,
   output logic [ADDR_W-1:0] o_reqAddr,
   input  logic              i_reqReady,
   input  logic              i_rvalid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [DATA_W-1:0] o_rdData,
   output logic [15:0]       o_rdCnt,
   output logic [DATA_W-1:0] o_chksum
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_trace [DEPTH];
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W:0]    r_len;
   logic              r_oneShot;
   logic              r_stopPend;
   logic              r_reqValid;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [DATA_W-1:0] r_rdData;
   logic [15:0]       r_rdCnt;
   logic [DATA_W-1:0] r_chksum;

   logic w_lenOk;
   logic w_startOk;
   logic w_startBad;
   logic w_capture;
   logic w_lastIdx;

   assign w_lenOk    = (i_len != '0) && (i_len <= DEPTH_L);
   assign w_startOk  = (r_state == IDLE) && i_start && w_lenOk;
   assign w_startBad = (r_state == IDLE) && i_start && !w_lenOk;
   assign w_capture  = (r_state == WAIT) && i_rvalid;
   assign w_lastIdx  = ({1'b0, r_idx} == (r_len - 1'b1));

   // The trace table is only writable while idle so a running pass always sees
   // a stable table; it is deliberately left out of reset so it survives aborts.
   always_ff @(posedge clk) begin
      if (i_ldEn && (r_state == IDLE)) begin
         r_trace[i_ldIdx] <= i_ldAddr;
      end
   end

   // Next-state decode. A pending stop only takes effect once the outstanding
   // read has returned, so the response is never lost on the bus.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_startOk) begin
               w_nextState = REQ;
            end
         end
         REQ: begin
            if (i_stop) begin
               w_nextState = IDLE;
            end else if (i_reqReady) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (i_rvalid) begin
               if (r_stopPend || i_stop) begin
                  w_nextState = IDLE;
               end else if (w_lastIdx && r_oneShot) begin
                  w_nextState = DONE;
               end else begin
                  w_nextState = REQ;
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State, status flags and response accumulation. Flags are registered from
   // the next state so they line up exactly with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_len      <= '0;
         r_oneShot  <= 1'b0;
         r_stopPend <= 1'b0;
         r_reqValid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rdData   <= '0;
         r_rdCnt    <= '0;
         r_chksum   <= '0;
      end else begin
         r_state    <= w_nextState;
         r_reqValid <= (w_nextState == REQ);
         r_busy     <= (w_nextState != IDLE);
         r_done     <= (w_nextState == DONE);
         r_err      <= w_startBad;
         if (w_startOk) begin
            r_len      <= i_len;
            r_oneShot  <= i_oneShot;
            r_idx      <= '0;
            r_rdCnt    <= '0;
            r_chksum   <= '0;
            r_stopPend <= 1'b0;
         end
         if (w_capture) begin
            r_rdData   <= i_data;
            r_chksum   <= r_chksum ^ i_data;
            r_stopPend <= 1'b0;
            if (r_rdCnt != 16'hFFFF) begin
               r_rdCnt <= r_rdCnt + 16'd1;
            end
            if (w_lastIdx) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end else if ((r_state == WAIT) && i_stop) begin
            r_stopPend <= 1'b1;
         end
      end
   end

   assign o_reqAddr  = (r_state == REQ) ? r_trace[r_idx] : '0;
   assign o_reqValid = r_reqValid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_rdData   = r_rdData;
   assign o_rdCnt    = r_rdCnt;
   assign o_chksum   = r_chksum;

endmodule

// File: tb/tb_processor_seq.sv
// Testbench for processor_seq: table of runs plus hand-written corner cases,
// with a queue of expected request addresses checked at every handshake.
module tb_processor_seq;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_ldEn = 1'b0;
   logic [IDX_W-1:0]  i_ldIdx = '0;
   logic [ADDR_W-1:0] i_ldAddr = '0;
   logic              i_start = 1'b0;
   logic [IDX_W:0]    i_len = '0;
   logic              i_oneShot = 1'b0;
   logic              i_stop = 1'b0;
   logic              o_reqValid;
   logic [ADDR_W-1:0] o_reqAddr;
   logic              i_reqReady = 1'b0;
   logic              i_rvalid = 1'b0;
   logic [DATA_W-1:0] i_data = '0;
   logic              o_busy;
   logic              o_done;
   logic              o_err;
   logic [DATA_W-1:0] o_rdData;
   logic [15:0]       o_rdCnt;
   logic [DATA_W-1:0] o_chksum;

   processor_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ldEn(i_ldEn), .i_ldIdx(i_ldIdx), .i_ldAddr(i_ldAddr),
      .i_start(i_start), .i_len(i_len), .i_oneShot(i_oneShot), .i_stop(i_stop),
      .o_reqValid(o_reqValid), .o_reqAddr(o_reqAddr), .i_reqReady(i_reqReady),
      .i_rvalid(i_rvalid), .i_data(i_data),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_rdData(o_rdData), .o_rdCnt(o_rdCnt), .o_chksum(o_chksum)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Pulse counters for the one-cycle done/err outputs, sampled mid-cycle.
   int doneCnt = 0;
   int errCnt  = 0;
   always @(negedge clk) begin
      if (o_done) doneCnt++;
      if (o_err)  errCnt++;
   end

   typedef struct {
      int len;
      bit oneShot;
      int nResp;
      int rdyDly;
      int rvDly;
      int expDone;
      bit expBusy;
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic [ADDR_W-1:0] tr [DEPTH];
   logic [ADDR_W-1:0] expAddrQ [$];
   logic [15:0]       modelCnt  = '0;
   logic [DATA_W-1:0] modelSum  = '0;
   logic [DATA_W-1:0] modelLast = '0;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues a start and, for a legal length, queues the addresses the run
   // should request for its first nResp accesses.
   task automatic applyStimulus(input int len, input bit os, input int nResp);
      i_start   = 1'b1;
      i_len     = len[IDX_W:0];
      i_oneShot = os;
      tick();
      i_start = 1'b0;
      if (len >= 1 && len <= DEPTH) begin
         modelCnt = '0;
         modelSum = '0;
         for (int k = 0; k < nResp; k++) expAddrQ.push_back(tr[k % len]);
      end
   endtask

   task automatic waitReqValid(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (o_reqValid) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
      checkOutput("reqValidTimeout", 64'd0, 64'd1);
   endtask

   // One request/response: holds ready low rdyDly cycles, handshakes, then
   // returns data d after rvDly idle WAIT cycles.
   task automatic doAccess(input logic [DATA_W-1:0] d, input int rdyDly, input int rvDly);
      bit ok;
      logic [ADDR_W-1:0] exp;
      waitReqValid(ok);
      if (!ok) return;
      if (expAddrQ.size() == 0) begin
         checkOutput("addrQueueEmpty", 64'd1, 64'd0);
         exp = '1;
      end else begin
         exp = expAddrQ.pop_front();
      end
      for (int c = 0; c < rdyDly; c++) begin
         checkOutput("addrHold", 64'(o_reqAddr), 64'(exp));
         tick();
      end
      checkOutput("reqAddr", 64'(o_reqAddr), 64'(exp));
      i_reqReady = 1'b1;
      tick();
      i_reqReady = 1'b0;
      checkOutput("reqValidInWait", 64'(o_reqValid), 64'd0);
      repeat (rvDly) tick();
      i_rvalid = 1'b1;
      i_data   = d;
      tick();
      i_rvalid = 1'b0;
      if (modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      modelSum  = modelSum ^ d;
      modelLast = d;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, ".rdCnt"},  64'(o_rdCnt),  64'(modelCnt));
      checkOutput({tag, ".chksum"}, 64'(o_chksum), 64'(modelSum));
      checkOutput({tag, ".rdData"}, 64'(o_rdData), 64'(modelLast));
   endtask

   initial begin
      vec_t vecs [5];
      int   d0;
      bit   ok;
      vecs[0] = '{len: 3,  oneShot: 1'b1, nResp: 3,  rdyDly: 0, rvDly: 0, expDone: 1, expBusy: 1'b0};
      vecs[1] = '{len: 3,  oneShot: 1'b0, nResp: 7,  rdyDly: 0, rvDly: 0, expDone: 0, expBusy: 1'b1};
      vecs[2] = '{len: 1,  oneShot: 1'b1, nResp: 1,  rdyDly: 2, rvDly: 1, expDone: 1, expBusy: 1'b0};
      vecs[3] = '{len: 16, oneShot: 1'b1, nResp: 16, rdyDly: 1, rvDly: 0, expDone: 1, expBusy: 1'b0};
      vecs[4] = '{len: 2,  oneShot: 1'b0, nResp: 5,  rdyDly: 0, rvDly: 2, expDone: 0, expBusy: 1'b1};

      // Reset state.
      repeat (3) tick();
      checkOutput("rst.reqValid", 64'(o_reqValid), 64'd0);
      checkOutput("rst.busy",     64'(o_busy),     64'd0);
      checkCounters("rst");
      rst_n = 1'b1;
      tick();

      // Load the full trace: 0x10, 0x20, 0x30, ...
      for (int i = 0; i < DEPTH; i++) begin
         tr[i]    = 32'(16 * (i + 1));
         i_ldEn   = 1'b1;
         i_ldIdx  = i[IDX_W-1:0];
         i_ldAddr = tr[i];
         tick();
      end
      i_ldEn = 1'b0;

      // Table of complete runs.
      for (int v = 0; v < 5; v++) begin
         d0 = doneCnt;
         applyStimulus(vecs[v].len, vecs[v].oneShot, vecs[v].nResp);
         for (int k = 0; k < vecs[v].nResp; k++)
            doAccess((32'h1 << (k % 24)) | (32'(v) << 24), vecs[v].rdyDly, vecs[v].rvDly);
         tick();
         tick();
         checkOutput($sformatf("v%0d.done", v), 64'(doneCnt - d0), 64'(vecs[v].expDone));
         checkOutput($sformatf("v%0d.busy", v), 64'(o_busy), 64'(vecs[v].expBusy));
         checkCounters($sformatf("v%0d", v));
         if (vecs[v].expBusy) begin
            i_stop = 1'b1;
            tick();
            i_stop = 1'b0;
            checkOutput($sformatf("v%0d.stopBusy", v), 64'(o_busy), 64'd0);
            checkOutput($sformatf("v%0d.stopValid", v), 64'(o_reqValid), 64'd0);
            checkOutput($sformatf("v%0d.stopAddr", v), 64'(o_reqAddr), 64'd0);
            tick();
            checkOutput($sformatf("v%0d.noDone", v), 64'(doneCnt - d0), 64'd0);
         end
      end

      // Illegal lengths: err pulse, stay idle, counters untouched.
      d0 = errCnt;
      applyStimulus(0, 1'b1, 0);
      checkOutput("len0.busy", 64'(o_busy), 64'd0);
      tick();
      applyStimulus(DEPTH + 1, 1'b1, 0);
      checkOutput("len17.busy", 64'(o_busy), 64'd0);
      tick();
      checkOutput("err.count", 64'(errCnt - d0), 64'd2);
      checkCounters("err");

      // Stall in REQ: address held, stray rvalid ignored.
      applyStimulus(3, 1'b1, 0);
      for (int c = 0; c < 5; c++) begin
         checkOutput("stall.valid", 64'(o_reqValid), 64'd1);
         checkOutput("stall.addr",  64'(o_reqAddr),  64'h10);
         i_rvalid = (c == 2);
         i_data   = 32'h55;
         tick();
      end
      i_rvalid = 1'b0;
      checkCounters("stall");
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      checkOutput("stall.stopBusy", 64'(o_busy), 64'd0);

      // Trace write during a run is ignored.
      applyStimulus(1, 1'b1, 1);
      i_ldEn = 1'b1; i_ldIdx = '0; i_ldAddr = 32'hDEAD;
      tick();
      i_ldEn = 1'b0;
      doAccess(32'h9, 0, 0);
      tick(); tick();
      applyStimulus(1, 1'b1, 1);
      doAccess(32'hA, 0, 0);
      tick(); tick();
      checkCounters("ldRun");

      // Trace write in the same cycle as start takes effect.
      i_ldEn = 1'b1; i_ldIdx = 4'd1; i_ldAddr = 32'h77;
      tr[1] = 32'h77;
      applyStimulus(2, 1'b1, 2);
      i_ldEn = 1'b0;
      doAccess(32'h3, 0, 0);
      doAccess(32'h6, 0, 0);
      tick(); tick();
      i_ldEn = 1'b1; i_ldAddr = 32'h20;
      tr[1] = 32'h20;
      tick();
      i_ldEn = 1'b0;

      // Stop while waiting for data: response still captured, no done.
      d0 = doneCnt;
      applyStimulus(3, 1'b1, 0);
      waitReqValid(ok);
      checkOutput("stopWait.addr", 64'(o_reqAddr), 64'h10);
      i_reqReady = 1'b1;
      tick();
      i_reqReady = 1'b0;
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      tick();
      checkOutput("stopWait.busy", 64'(o_busy), 64'd1);
      i_rvalid = 1'b1; i_data = 32'hAA;
      tick();
      i_rvalid = 1'b0;
      modelCnt = 16'd1; modelSum = 32'hAA; modelLast = 32'hAA;
      checkOutput("stopWait.idle", 64'(o_busy), 64'd0);
      i_rvalid = 1'b1; i_data = 32'h1;
      tick();
      i_rvalid = 1'b0;
      tick();
      checkCounters("stopWait");
      checkOutput("stopWait.noDone", 64'(doneCnt - d0), 64'd0);

      // Asynchronous reset while in WAIT, then restart from the retained trace.
      applyStimulus(3, 1'b1, 1);
      doAccess(32'h5, 0, 0);
      waitReqValid(ok);
      i_reqReady = 1'b1;
      tick();
      i_reqReady = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      modelCnt = '0; modelSum = '0; modelLast = '0;
      checkOutput("arst.reqValid", 64'(o_reqValid), 64'd0);
      checkOutput("arst.reqAddr",  64'(o_reqAddr),  64'd0);
      checkOutput("arst.busy",     64'(o_busy),     64'd0);
      checkOutput("arst.done",     64'(o_done),     64'd0);
      checkOutput("arst.err",      64'(o_err),      64'd0);
      checkCounters("arst");
      tick();
      rst_n = 1'b1;
      tick();
      d0 = doneCnt;
      applyStimulus(2, 1'b1, 2);
      doAccess(32'h3, 0, 0);
      doAccess(32'h5, 0, 0);
      tick(); tick();
      checkOutput("restart.done", 64'(doneCnt - d0), 64'd1);
      checkCounters("restart");
      checkOutput("queueDrained", 64'(expAddrQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
